// File: rtl/fifo_pkg.sv
// Shared constants for the parametrised synchronous FIFO.
package fifo_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 8;

  // Read-mode selectors for the FWFT parameter.
  localparam int FWFT_OFF = 0;  // registered read, data after the accepting edge
  localparam int FWFT_ON  = 1;  // head word always visible on data_out

  // Pointer width: DEPTH is a power of two so pointers wrap naturally.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy width: one extra bit so DEPTH itself is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEFAULT_ADDR_W = $clog2(DEFAULT_DEPTH);
  localparam int DEFAULT_CNT_W  = $clog2(DEFAULT_DEPTH) + 1;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DATA_W array, synchronous write, asynchronous read.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  // Contents are deliberately not reset; pointers/count define validity.
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write port: store on accepted write.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy, thresholds, error pulses
// and optional first-word-fall-through read mode.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = FWFT_OFF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [DATA_W-1:0]        i_data_in,
  input  logic                     i_rd_en,
  output logic [DATA_W-1:0]        o_data_out,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_almost_full,
  output logic                     o_almost_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);

  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow, r_underflow;
  logic              w_full, w_empty;
  logic              w_wr_acc, w_rd_acc, w_we;
  logic [DATA_W-1:0] w_rdata;

  // Flags come only from the registered count: no input-to-flag paths.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // A read frees a slot in the same cycle, so a write at full is still
  // accepted when paired with a read.
  assign w_rd_acc = i_rd_en && !w_empty;
  assign w_wr_acc = i_wr_en && (!w_full || w_rd_acc);
  assign w_we     = w_wr_acc && !i_rst;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Pointers, occupancy and reject pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_overflow  <= i_wr_en && !w_wr_acc;
      r_underflow <= i_rd_en && !w_rd_acc;
    end
  end

  generate
    if (FWFT == FWFT_ON) begin : g_fwft
      // Head word is shown directly; valid whenever not empty.
      assign o_data_out = w_rdata;
    end else begin : g_std
      logic [DATA_W-1:0] r_data_out;
      // Registered read: capture head on an accepted read, hold otherwise.
      always_ff @(posedge i_clk) begin
        if (i_rst)         r_data_out <= '0;
        else if (w_rd_acc) r_data_out <= w_rdata;
      end
      assign o_data_out = r_data_out;
    end
  endgenerate

  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (r_count >= CNT_W'(AF_THRESH));
  assign o_almost_empty = (r_count <= CNT_W'(AE_THRESH));
  assign o_count        = r_count;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench: one standard-read and one FWFT instance share the same stimulus;
// a queue model predicts occupancy, flags, pulses and read data.
module tb_sync_fifo_param;

  localparam int DW  = 32;
  localparam int DP  = 8;
  localparam int AF  = DP - 1;
  localparam int AE  = 1;
  localparam int CW  = $clog2(DP) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] din = '0;

  logic [DW-1:0] a_dout, b_dout;
  logic          a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  logic          b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [CW-1:0] a_cnt, b_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  bit            m_ovf, m_udf;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_std (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_data_in(din), .i_rd_en(rd_en),
    .o_data_out(a_dout), .o_full(a_full), .o_empty(a_empty), .o_almost_full(a_af),
    .o_almost_empty(a_ae), .o_count(a_cnt), .o_overflow(a_ovf), .o_underflow(a_udf));

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fwft (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_data_in(din), .i_rd_en(rd_en),
    .o_data_out(b_dout), .o_full(b_full), .o_empty(b_empty), .o_almost_full(b_af),
    .o_almost_empty(b_ae), .o_count(b_cnt), .o_overflow(b_ovf), .o_underflow(b_udf));

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare both instances against the model's post-edge state.
  task automatic compare(input string tag);
    int n;
    n = q.size();
    chk({tag, " cnt"},   DW'(a_cnt), DW'(n));
    chk({tag, " full"},  DW'(a_full), DW'(n == DP));
    chk({tag, " empty"}, DW'(a_empty), DW'(n == 0));
    chk({tag, " af"},    DW'(a_af), DW'(n >= AF));
    chk({tag, " ae"},    DW'(a_ae), DW'(n <= AE));
    chk({tag, " ovf"},   DW'(a_ovf), DW'(m_ovf));
    chk({tag, " udf"},   DW'(a_udf), DW'(m_udf));
    chk({tag, " dout"},  a_dout, m_dout);
    chk({tag, " f.cnt"}, DW'(b_cnt), DW'(n));
    chk({tag, " f.empty"}, DW'(b_empty), DW'(n == 0));
    chk({tag, " f.ovf"}, DW'(b_ovf), DW'(m_ovf));
    chk({tag, " f.udf"}, DW'(b_udf), DW'(m_udf));
    if (n > 0) chk({tag, " f.dout"}, b_dout, q[0]);
  endtask

  // One clock of traffic; the model applies the FIFO rules to the queue.
  task automatic step(input string tag, input bit wr, input logic [DW-1:0] d, input bit rd);
    bit rd_ok, wr_ok;
    wr_en = wr; din = d; rd_en = rd;
    @(posedge clk);
    rd_ok = rd && (q.size() > 0);
    wr_ok = wr && ((q.size() < DP) || rd_ok);
    if (rd_ok) m_dout = q.pop_front();
    if (wr_ok) q.push_back(d);
    m_ovf = wr && !wr_ok;
    m_udf = rd && !rd_ok;
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
    compare(tag);
  endtask

  // Reset cycle with requests asserted: they must be ignored.
  task automatic do_reset(input string tag);
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; din = 32'hDEAD_BEEF;
    @(posedge clk);
    q.delete();
    m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
    #1;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    compare(tag);
  endtask

  initial begin
    m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
    do_reset("reset");

    // Fill with squares, then one write too many.
    for (int i = 0; i < DP; i++) step("fill_sq", 1'b1, DW'(i * i), 1'b0);
    step("overflow", 1'b1, 32'd64, 1'b0);
    step("overflow2", 1'b1, 32'd65, 1'b0);
    step("ovf_clear", 1'b0, '0, 1'b0);

    // Drain nine times; last one underflows and data holds 49.
    for (int i = 0; i < DP + 1; i++) step("drain_sq", 1'b0, '0, 1'b1);
    chk("drain_last49", a_dout, 32'd49);
    step("udf_clear", 1'b0, '0, 1'b0);

    // Simultaneous at full, then drain to see the wrapped word.
    for (int i = 0; i < DP; i++) step("fill_rnd", 1'b1, $urandom, 1'b0);
    step("full_wr_rd", 1'b1, 32'd100, 1'b1);
    for (int i = 0; i < DP; i++) step("drain_wrap", 1'b0, '0, 1'b1);
    chk("wrap_last100", a_dout, 32'd100);

    // Simultaneous at empty: write lands, read underflows.
    step("empty_wr_rd", 1'b1, 32'd7, 1'b1);
    step("read7", 1'b0, '0, 1'b1);
    chk("read7_val", a_dout, 32'd7);

    // FWFT sequence (checked through the model's head-of-queue compare).
    do_reset("reset2");
    step("fwft_w10", 1'b1, 32'd10, 1'b0);
    chk("fwft_10", b_dout, 32'd10);
    step("fwft_w20", 1'b1, 32'd20, 1'b0);
    step("fwft_rd1", 1'b0, '0, 1'b1);
    chk("fwft_20", b_dout, 32'd20);
    step("fwft_rd2", 1'b0, '0, 1'b1);
    chk("fwft_empty", DW'(b_empty), DW'(1));

    // Random traffic with varying bias toward writes or reads.
    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = (i / 100) % 2 ? 30 : 70;
      step("random", ($urandom_range(99) < wp), $urandom, ($urandom_range(99) < 100 - wp + 10));
    end

    // Reset mid-stream with count at 5, then read underflows.
    do_reset("reset3");
    for (int i = 0; i < 5; i++) step("fill5", 1'b1, $urandom, 1'b0);
    chk("cnt5", DW'(a_cnt), DW'(5));
    do_reset("reset_mid");
    step("post_rst_rd", 1'b0, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
